// File: rtl/id_ex_stage_pkg.sv
// Shared decode definitions: ALUOp encodings, the zero-register constant and
// the control bundle that travels Control -> ID/EX -> EX/MEM.
package id_ex_stage_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b11;

   localparam int               REG_AW_DEF = 5;
   localparam logic [REG_AW_DEF-1:0] REG_ZERO = '0;

   // aluop is a plain vector so undefined encodings pass through untouched
   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memwrite;
      logic       memread;
      logic [1:0] aluop;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use compare between the load sitting in EX and the
// source registers of the instruction in ID.
module load_use_detect
   import id_ex_stage_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              ex_memread_i,
   input  logic [REG_AW-1:0] ex_rt_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   output logic              hazard_o
);

   // Register 0 is hard-wired, so a load into it can never be a dependency
   assign hazard_o = ex_memread_i
                   && (ex_rt_i != REG_AW'(REG_ZERO))
                   && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated load-use bubble insertion,
// stall/flush handling and a saturating bubble counter.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              id_regdst_i,
   input  logic              id_alusrc_i,
   input  logic              id_memtoreg_i,
   input  logic              id_regwrite_i,
   input  logic              id_memwrite_i,
   input  logic              id_memread_i,
   input  logic [1:0]        id_aluop_i,
   input  logic [DATA_W-1:0] id_rs_data_i,
   input  logic [DATA_W-1:0] id_rt_data_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   output logic              ex_regdst_o,
   output logic              ex_alusrc_o,
   output logic              ex_memtoreg_o,
   output logic              ex_regwrite_o,
   output logic              ex_memwrite_o,
   output logic              ex_memread_o,
   output logic [1:0]        ex_aluop_o,
   output logic [DATA_W-1:0] ex_rs_data_o,
   output logic [DATA_W-1:0] ex_rt_data_o,
   output logic [DATA_W-1:0] ex_imm_o,
   output logic [REG_AW-1:0] ex_rs_o,
   output logic [REG_AW-1:0] ex_rt_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic              hazard_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   ctrl_t             id_ctrl;
   ctrl_t             ctrl_d, ctrl_q;
   logic [DATA_W-1:0] rs_data_d, rs_data_q;
   logic [DATA_W-1:0] rt_data_d, rt_data_q;
   logic [DATA_W-1:0] imm_d, imm_q;
   logic [REG_AW-1:0] rs_d, rs_q;
   logic [REG_AW-1:0] rt_d, rt_q;
   logic [REG_AW-1:0] rd_d, rd_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic              hazard;
   logic              bubble;

   assign id_ctrl = '{regdst:   id_regdst_i,
                      alusrc:   id_alusrc_i,
                      memtoreg: id_memtoreg_i,
                      regwrite: id_regwrite_i,
                      memwrite: id_memwrite_i,
                      memread:  id_memread_i,
                      aluop:    id_aluop_i};

   load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
      .ex_memread_i (ctrl_q.memread),
      .ex_rt_i      (rt_q),
      .id_rs_i      (id_rs_i),
      .id_rt_i      (id_rt_i),
      .hazard_o     (hazard)
   );

   assign bubble = flush_i || hazard;

   // A bubble only kills the controls; operand fields are still captured
   always_comb begin
      ctrl_d    = ctrl_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      if (!stall_i) begin
         ctrl_d    = bubble ? CTRL_NOP : id_ctrl;
         rs_data_d = id_rs_data_i;
         rt_data_d = id_rt_data_i;
         imm_d     = id_imm_i;
         rs_d      = id_rs_i;
         rt_d      = id_rt_i;
         rd_d      = id_rd_i;
         if (bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ctrl_q    <= CTRL_NOP;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
      end
   end

   assign ex_regdst_o   = ctrl_q.regdst;
   assign ex_alusrc_o   = ctrl_q.alusrc;
   assign ex_memtoreg_o = ctrl_q.memtoreg;
   assign ex_regwrite_o = ctrl_q.regwrite;
   assign ex_memwrite_o = ctrl_q.memwrite;
   assign ex_memread_o  = ctrl_q.memread;
   assign ex_aluop_o    = ctrl_q.aluop;
   assign ex_rs_data_o  = rs_data_q;
   assign ex_rt_data_o  = rt_data_q;
   assign ex_imm_o      = imm_q;
   assign ex_rs_o       = rs_q;
   assign ex_rt_o       = rt_q;
   assign ex_rd_o       = rd_q;
   assign hazard_o      = hazard;
   assign bubble_cnt_o  = cnt_q;

endmodule
